// File: rtl/ysyx_22050019_axi_pkg.sv
// Shared encodings for the read responder: FSM states and AXI-style response codes.
package ysyx_22050019_axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

endpackage

// File: rtl/ysyx_22050019_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded to 8'h01 on reset; source of random WAIT stretch.
module ysyx_22050019_lfsr8 (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] state_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 8'h01;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/ysyx_22050019_rd_responder.sv
// Single-outstanding read responder over a preloadable word array with fixed response latency.
// Define YSYX_22050019_RD_RESPONDER_RAND_DELAY_EN to stretch each WAIT by 0..3 LFSR-chosen cycles.
module ysyx_22050019_rd_responder
    import ysyx_22050019_axi_pkg::*;
#(
    parameter int          DATA_WIDTH = 64,
    parameter int          ADDR_WIDTH = 64,
    parameter int          DEPTH      = 256,
    parameter logic [63:0] BASE       = 64'h8000_0000,
    parameter int          LATENCY    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ar_valid_i,
    output logic                     ar_ready_o,
    input  logic [ADDR_WIDTH-1:0]    ar_addr_i,
    output logic                     r_valid_o,
    input  logic                     r_ready_i,
    output logic [1:0]               r_resp_o,
    output logic [DATA_WIDTH-1:0]    r_data_o,
    input  logic                     ld_en_i,
    input  logic [$clog2(DEPTH)-1:0] ld_idx_i,
    input  logic [DATA_WIDTH-1:0]    ld_data_i
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BASE_A  = ADDR_WIDTH'(BASE);
    localparam logic [ADDR_WIDTH-1:0] LIMIT_A = ADDR_WIDTH'(DEPTH) << 3;

    rd_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [4:0]            cnt_q, cnt_d;
    resp_e                 r_resp_q;
    logic [DATA_WIDTH-1:0] r_data_q;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [1:0]            extra_wait;
    logic [4:0]            total_wait;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic [ADDR_WIDTH-1:0] offset;
    logic [IDX_W-1:0]      word_idx;
    logic                  in_range;
    resp_e                 resp_sel;
    logic [DATA_WIDTH-1:0] data_sel;
    logic                  load_rsp;

`ifdef YSYX_22050019_RD_RESPONDER_RAND_DELAY_EN
    logic [7:0] lfsr_value;

    ysyx_22050019_lfsr8 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .state_o (lfsr_value)
    );

    assign extra_wait = lfsr_value[1:0];
`else
    assign extra_wait = 2'd0;
`endif

    assign total_wait = 5'(LATENCY) + {3'b000, extra_wait};

    // In IDLE the live request address is decoded so LATENCY=0 can respond next cycle.
    always_comb begin
        addr_sel = (state_q == ST_IDLE) ? ar_addr_i : addr_q;
        offset   = addr_sel - BASE_A;
        word_idx = offset[IDX_W+2:3];
        in_range = (addr_sel >= BASE_A) && (offset < LIMIT_A);
        resp_sel = RESP_OKAY;
        data_sel = '0;
        if (addr_sel[2:0] != 3'b000) begin
            resp_sel = RESP_SLVERR;
        end else if (!in_range) begin
            resp_sel = RESP_DECERR;
        end else begin
            data_sel = mem_q[word_idx];
        end
    end

    // NOTE: every variable gets a default before the case so no latch can be inferred.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        load_rsp = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (ar_valid_i) begin
                    addr_d = ar_addr_i;
                    if (total_wait == 5'd0) begin
                        state_d  = ST_RESP;
                        load_rsp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = total_wait - 5'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 5'd0) begin
                    state_d  = ST_RESP;
                    load_rsp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ST_RESP: begin
                if (r_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            cnt_q    <= 5'd0;
            r_resp_q <= RESP_OKAY;
            r_data_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            if (load_rsp) begin
                r_resp_q <= resp_sel;
                r_data_q <= data_sel;
            end
        end
    end

    // NOTE: the array is storage only, so it is not reset; a same-edge preload leaves the sampled word old.
    always_ff @(posedge clk) begin
        if (ld_en_i) begin
            mem_q[ld_idx_i] <= ld_data_i;
        end
    end

    assign ar_ready_o = (state_q == ST_IDLE);
    assign r_valid_o  = (state_q == ST_RESP);
    assign r_resp_o   = r_resp_q;
    assign r_data_o   = r_data_q;

endmodule
